// File: rtl/ex_hazard_scheduler.sv
// Execute-stage issue/hazard controller: tracks EX/MEM/WB producers, decides
// issue/stall/squash for the ID instruction and registers the ALU forwarding selects.
module ex_hazard_scheduler #(
    parameter int REG_ADDR_LEN = 4,
    parameter bit FORWARD_EN   = 1'b1,
    parameter int CNT_LEN      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_ADDR_LEN-1:0] id_src1,
    input  logic [REG_ADDR_LEN-1:0] id_src2,
    input  logic                    id_use_src1,
    input  logic                    id_use_src2,
    input  logic [REG_ADDR_LEN-1:0] id_dest,
    input  logic                    id_wb_en,
    input  logic                    id_mem_r_en,
    input  logic                    ex_branch_taken,
    output logic                    stall,
    output logic                    flush_if_id,
    output logic                    flush_id_ex,
    output logic [1:0]              alu_mux_sel_src1,
    output logic [1:0]              alu_mux_sel_src2,
    output logic [CNT_LEN-1:0]      stall_count,
    output logic [CNT_LEN-1:0]      flush_count
);

    typedef struct packed {
        logic                    valid;
        logic [REG_ADDR_LEN-1:0] dest;
        logic                    wb_en;
        logic                    mem_r_en;
    } shadow_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    shadow_t ex_q, mem_q, wb_q, ex_d;
    logic    hit_ex1, hit_ex2, hit_mem1, hit_mem2, hit_wb1, hit_wb2;
    logic    hazard, issue;
    logic [1:0] sel1_d, sel2_d;

    function automatic logic src_hit(input shadow_t s, input logic use_src,
                                     input logic [REG_ADDR_LEN-1:0] src);
        return use_src & s.valid & s.wb_en & (s.dest == src);
    endfunction

    assign hit_ex1  = src_hit(ex_q,  id_use_src1, id_src1);
    assign hit_ex2  = src_hit(ex_q,  id_use_src2, id_src2);
    assign hit_mem1 = src_hit(mem_q, id_use_src1, id_src1);
    assign hit_mem2 = src_hit(mem_q, id_use_src2, id_src2);
    assign hit_wb1  = src_hit(wb_q,  id_use_src1, id_src1);
    assign hit_wb2  = src_hit(wb_q,  id_use_src2, id_src2);

    // With forwarding only a load in EX is unresolvable; without it, any
    // in-flight producer blocks until it has left WB (no same-cycle RF bypass).
    assign hazard = FORWARD_EN ? ((hit_ex1 | hit_ex2) & ex_q.mem_r_en)
                               : (hit_ex1 | hit_ex2 | hit_mem1 | hit_mem2 | hit_wb1 | hit_wb2);

    assign stall       = id_valid & hazard & ~ex_branch_taken;
    assign flush_if_id = ex_branch_taken;
    assign flush_id_ex = stall | ex_branch_taken;
    assign issue       = id_valid & ~stall & ~ex_branch_taken;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ex_d   = '0;
        sel1_d = SEL_RF;
        sel2_d = SEL_RF;
        if (issue) begin
            ex_d = '{valid: 1'b1, dest: id_dest, wb_en: id_wb_en, mem_r_en: id_mem_r_en};
            if (FORWARD_EN) begin
                // EX becomes MEM next cycle, so the younger producer takes priority.
                if (hit_ex1)       sel1_d = SEL_MEM;
                else if (hit_mem1) sel1_d = SEL_WB;
                if (hit_ex2)       sel2_d = SEL_MEM;
                else if (hit_mem2) sel2_d = SEL_WB;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q             <= '0;
            mem_q            <= '0;
            wb_q             <= '0;
            alu_mux_sel_src1 <= SEL_RF;
            alu_mux_sel_src2 <= SEL_RF;
        end else begin
            wb_q             <= mem_q;
            mem_q            <= ex_q;
            ex_q             <= ex_d;
            alu_mux_sel_src1 <= sel1_d;
            alu_mux_sel_src2 <= sel2_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1))
                stall_count <= stall_count + CNT_LEN'(1);
            if (flush_if_id && (flush_count != '1))
                flush_count <= flush_count + CNT_LEN'(1);
        end
    end

endmodule

// File: tb/tb_ex_hazard_scheduler.sv
// Scoreboard bench for ex_hazard_scheduler: forwarding, no-forwarding and
// narrow-counter instances share one stimulus stream; each expectation names its instance.
module tb_ex_hazard_scheduler;

    typedef struct packed {
        logic       valid;
        logic [3:0] src1;
        logic [3:0] src2;
        logic       use1;
        logic       use2;
        logic [3:0] dest;
        logic       wb;
        logic       ld;
    } ins_t;

    typedef struct {
        int          which;
        logic        stall;
        logic        fif;
        logic        fie;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic [15:0] sc;
        logic [15:0] fc;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ins_t id  = '0;
    logic br  = 1'b0;

    logic        stall_f, fif_f, fie_f, stall_n, fif_n, fie_n, stall_s, fif_s, fie_s;
    logic [1:0]  s1_f, s2_f, s1_n, s2_n, s1_s, s2_s;
    logic [15:0] sc_f, fc_f, sc_n, fc_n;
    logic [1:0]  sc_s, fc_s;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_hazard_scheduler #(.REG_ADDR_LEN(4), .FORWARD_EN(1'b1), .CNT_LEN(16)) dut_fwd (
        .clk(clk), .rst(rst), .id_valid(id.valid), .id_src1(id.src1), .id_src2(id.src2),
        .id_use_src1(id.use1), .id_use_src2(id.use2), .id_dest(id.dest), .id_wb_en(id.wb),
        .id_mem_r_en(id.ld), .ex_branch_taken(br), .stall(stall_f), .flush_if_id(fif_f),
        .flush_id_ex(fie_f), .alu_mux_sel_src1(s1_f), .alu_mux_sel_src2(s2_f),
        .stall_count(sc_f), .flush_count(fc_f));

    ex_hazard_scheduler #(.REG_ADDR_LEN(4), .FORWARD_EN(1'b0), .CNT_LEN(16)) dut_nf (
        .clk(clk), .rst(rst), .id_valid(id.valid), .id_src1(id.src1), .id_src2(id.src2),
        .id_use_src1(id.use1), .id_use_src2(id.use2), .id_dest(id.dest), .id_wb_en(id.wb),
        .id_mem_r_en(id.ld), .ex_branch_taken(br), .stall(stall_n), .flush_if_id(fif_n),
        .flush_id_ex(fie_n), .alu_mux_sel_src1(s1_n), .alu_mux_sel_src2(s2_n),
        .stall_count(sc_n), .flush_count(fc_n));

    ex_hazard_scheduler #(.REG_ADDR_LEN(4), .FORWARD_EN(1'b1), .CNT_LEN(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id.valid), .id_src1(id.src1), .id_src2(id.src2),
        .id_use_src1(id.use1), .id_use_src2(id.use2), .id_dest(id.dest), .id_wb_en(id.wb),
        .id_mem_r_en(id.ld), .ex_branch_taken(br), .stall(stall_s), .flush_if_id(fif_s),
        .flush_id_ex(fie_s), .alu_mux_sel_src1(s1_s), .alu_mux_sel_src2(s2_s),
        .stall_count(sc_s), .flush_count(fc_s));

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic ins_t alu(input logic [3:0] d, input logic [3:0] a, input logic [3:0] b);
        ins_t i = '0;
        i.valid = 1'b1; i.src1 = a; i.src2 = b; i.use1 = 1'b1; i.use2 = 1'b1;
        i.dest = d; i.wb = 1'b1;
        return i;
    endfunction

    function automatic ins_t alu1(input logic [3:0] d, input logic [3:0] a);
        ins_t i = '0;
        i.valid = 1'b1; i.src1 = a; i.use1 = 1'b1; i.dest = d; i.wb = 1'b1;
        return i;
    endfunction

    function automatic ins_t ldr(input logic [3:0] d, input logic [3:0] base);
        ins_t i = alu1(d, base);
        i.ld = 1'b1;
        return i;
    endfunction

    function automatic exp_t mk(input int which, input logic st, input logic ff, input logic fe,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [15:0] sc, input logic [15:0] fc, input string tag);
        exp_t e;
        e.which = which; e.stall = st; e.fif = ff; e.fie = fe;
        e.s1 = a; e.s2 = b; e.sc = sc; e.fc = fc; e.tag = tag;
        return e;
    endfunction

    // Monitor: one expectation per driven cycle, compared at the falling edge.
    initial begin
        exp_t e;
        logic st, ff, fe;
        logic [1:0] a1, a2;
        logic [15:0] asc, afc;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.which)
                    0: begin st = stall_f; ff = fif_f; fe = fie_f; a1 = s1_f; a2 = s2_f; asc = sc_f; afc = fc_f; end
                    1: begin st = stall_n; ff = fif_n; fe = fie_n; a1 = s1_n; a2 = s2_n; asc = sc_n; afc = fc_n; end
                    default: begin
                        st = stall_s; ff = fif_s; fe = fie_s; a1 = s1_s; a2 = s2_s;
                        asc = {14'b0, sc_s}; afc = {14'b0, fc_s};
                    end
                endcase
                check({e.tag, ".stall"}, 16'(st), 16'(e.stall));
                check({e.tag, ".flush_if_id"}, 16'(ff), 16'(e.fif));
                check({e.tag, ".flush_id_ex"}, 16'(fe), 16'(e.fie));
                check({e.tag, ".sel_src1"}, 16'(a1), 16'(e.s1));
                check({e.tag, ".sel_src2"}, 16'(a2), 16'(e.s2));
                check({e.tag, ".stall_count"}, asc, e.sc);
                check({e.tag, ".flush_count"}, afc, e.fc);
            end
        end
    end

    task automatic drive(input ins_t i, input logic b, input exp_t e);
        id = i;
        br = b;
        sb.push_back(e);
    endtask

    task automatic step(input ins_t i, input logic b, input exp_t e);
        drive(i, b, e);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        id  = '0;
        br  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #2 rst = 1'b0;
        #1;
        check("init.stall", 16'(stall_f), 16'd0);
        check("init.flush_id_ex", 16'(fie_f), 16'd0);
        check("init.sel_src1", 16'(s1_f), 16'd0);
        check("init.stall_count", sc_f, 16'd0);
        check("init.flush_count", fc_f, 16'd0);

        // 1: ALU-ALU back-to-back forwards from MEM.
        apply_reset();
        step(alu(4'd1, 4'd2, 4'd3), 1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t1_add"));
        step(alu(4'd2, 4'd1, 4'd3), 1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t1_sub_id"));
        step('0,                    1'b0, mk(0, 0, 0, 0, 2'b10, 2'b00, 0, 0, "t1_sub_ex"));

        // 2: distance-two dependency forwards from WB on src2.
        apply_reset();
        step(alu(4'd1, 4'd2, 4'd3), 1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t2_add"));
        step('0,                    1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t2_nop"));
        step(alu(4'd4, 4'd5, 4'd1), 1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t2_orr_id"));
        step('0,                    1'b0, mk(0, 0, 0, 0, 2'b00, 2'b01, 0, 0, "t2_orr_ex"));

        // 3: load-use costs one stall, then both sources come from WB.
        apply_reset();
        step(ldr(4'd3, 4'd4),       1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t3_ldr"));
        step(alu(4'd6, 4'd3, 4'd3), 1'b0, mk(0, 1, 0, 1, 2'b00, 2'b00, 0, 0, "t3_stall"));
        step(alu(4'd6, 4'd3, 4'd3), 1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 1, 0, "t3_issue"));
        step('0,                    1'b0, mk(0, 0, 0, 0, 2'b01, 2'b01, 1, 0, "t3_add_ex"));

        // 6: async reset in the middle of a load-use stall (stall_count carries 1 from case 3).
        step(ldr(4'd3, 4'd4),       1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 1, 0, "t6_ldr"));
        drive(alu(4'd6, 4'd3, 4'd3), 1'b0, mk(0, 1, 0, 1, 2'b00, 2'b00, 1, 0, "t6_stall"));
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t6_rst.stall", 16'(stall_f), 16'd0);
        check("t6_rst.flush_id_ex", 16'(fie_f), 16'd0);
        check("t6_rst.stall_count", sc_f, 16'd0);
        check("t6_rst.flush_count", fc_f, 16'd0);
        @(posedge clk);
        #1;
        check("t6_hold.stall", 16'(stall_f), 16'd0);
        check("t6_hold.stall_count", sc_f, 16'd0);
        rst = 1'b1;
        step(alu(4'd7, 4'd3, 4'd3), 1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t6_after"));
        step('0,                    1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t6_after_ex"));

        // 4: branch squash beats load-use; EX must get a bubble, not the ADD.
        apply_reset();
        step(ldr(4'd3, 4'd4),       1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t4_ldr"));
        step(alu(4'd6, 4'd3, 4'd3), 1'b1, mk(0, 0, 1, 1, 2'b00, 2'b00, 0, 0, "t4_flush"));
        step(alu1(4'd7, 4'd6),      1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, "t4_after"));
        step('0,                    1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, "t4_bubble"));

        // 7: the two sources forward from different stages.
        apply_reset();
        step(alu(4'd1, 4'd2, 4'd3), 1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t7_r1"));
        step(alu(4'd8, 4'd2, 4'd3), 1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t7_r8"));
        step(alu(4'd2, 4'd8, 4'd1), 1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t7_sub_id"));
        step('0,                    1'b0, mk(0, 0, 0, 0, 2'b10, 2'b01, 0, 0, "t7_sub_ex"));

        // 8: two producers of R1 in flight; the younger one wins.
        apply_reset();
        step(alu(4'd1, 4'd2, 4'd3), 1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t8_old"));
        step(alu(4'd1, 4'd4, 4'd5), 1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t8_young"));
        step(alu(4'd2, 4'd1, 4'd1), 1'b0, mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t8_sub_id"));
        step('0,                    1'b0, mk(0, 0, 0, 0, 2'b10, 2'b10, 0, 0, "t8_sub_ex"));

        // 5: no forwarding, stall until the producer has left WB.
        apply_reset();
        step(alu(4'd1, 4'd2, 4'd3), 1'b0, mk(1, 0, 0, 0, 2'b00, 2'b00, 0, 0, "t5_add"));
        step(alu(4'd2, 4'd1, 4'd3), 1'b0, mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 0, "t5_stall_ex"));
        step(alu(4'd2, 4'd1, 4'd3), 1'b0, mk(1, 1, 0, 1, 2'b00, 2'b00, 1, 0, "t5_stall_mem"));
        step(alu(4'd2, 4'd1, 4'd3), 1'b0, mk(1, 1, 0, 1, 2'b00, 2'b00, 2, 0, "t5_stall_wb"));
        step(alu(4'd2, 4'd1, 4'd3), 1'b0, mk(1, 0, 0, 0, 2'b00, 2'b00, 3, 0, "t5_issue"));
        step('0,                    1'b0, mk(1, 0, 0, 0, 2'b00, 2'b00, 3, 0, "t5_sub_ex"));

        // Saturation on the 2-bit counter instance.
        apply_reset();
        for (int k = 0; k < 5; k++)
            step('0, 1'b1, mk(2, 0, 1, 1, 2'b00, 2'b00, 0, (k < 3) ? 16'(k) : 16'd3,
                              $sformatf("sat_%0d", k)));
        step('0, 1'b0, mk(2, 0, 0, 0, 2'b00, 2'b00, 0, 3, "sat_hold"));

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
